// File: rtl/ethernet_stats_pkg.sv
// ethernet_stats_pkg
// Shared definitions for the Ethernet statistics collector:
//   - number of ether_stats_vector types and the bit index of each type
//   - sequencer state encoding
//   - small helper that sizes index fields safely when a count is 1
package ethernet_stats_pkg;

  localparam int N_OF_ETHER_STATS_TYPE = 7;
  localparam int STATS_TYPE_IDX_W      = $clog2(N_OF_ETHER_STATS_TYPE);

  // Bit positions inside ether_stats_vector; each one is also the counter index
  localparam int STATS_IDX_UNICAST   = 0;
  localparam int STATS_IDX_MULTICAST = 1;
  localparam int STATS_IDX_BROADCAST = 2;
  localparam int STATS_IDX_FCS_ERROR = 3;
  localparam int STATS_IDX_RUNT      = 4;
  localparam int STATS_IDX_OVERSIZE  = 5;
  localparam int STATS_IDX_VALID     = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    UPDATE = 2'd2
  } stats_fsm_e;

  // $clog2(1) is 0, which would give zero-width select ports
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ethernet_stats_rr_arbiter.sv
// ethernet_stats_rr_arbiter
// Round-robin arbiter: picks the first request at or after the rotating
// pointer. The pointer moves to one past the winner only when the
// requester actually consumes the grant (i_advance).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_req[N]        request vector
//   i_advance       grant consumed this cycle; rotate the pointer
//   o_grantOh[N]    one-hot grant
//   o_grantIdx      binary index of the granted requester
//   o_grantValid    at least one request is present
module ethernet_stats_rr_arbiter
  import ethernet_stats_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = idxWidth(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_advance,
  output logic [N-1:0]     o_grantOh,
  output logic [IDX_W-1:0] o_grantIdx,
  output logic             o_grantValid
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_cand;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // Scan requests starting at the pointer, wrapping modulo N; the candidate
  // is one bit wider so the wrap works for non-power-of-two N.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(i);
      if (w_cand >= (IDX_W+1)'(N)) begin
        w_cand = w_cand - (IDX_W+1)'(N);
      end
      if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    o_grantOh = '0;
    if (w_found) begin
      o_grantOh[w_idx] = 1'b1;
    end
  end

  assign o_grantIdx   = w_idx;
  assign o_grantValid = w_found;

  // Pointer rotates past the winner so it gets lowest priority next time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      if (w_idx == IDX_W'(N-1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/ethernet_stats_collector.sv
// ethernet_stats_collector
// Collects per-frame ether_stats_vector reports from N_PORTS MAC RX ports
// and keeps one saturating counter per (port, type). Each port has a single
// pending slot; a round-robin arbiter feeds one shared read-modify-write
// sequencer that walks a granted vector one type per cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   stats_valid    per-port one-cycle strobe qualifying stats_vector
//   stats_vector   port p at [p*N_TYPES +: N_TYPES]
//   stats_drop     per-port pulse: report lost because the slot was full
//   rd_en          host read strobe (samples rd_port/rd_type/rd_clear)
//   rd_port        port select
//   rd_type        type select (bit index in ether_stats_vector)
//   rd_clear       clear the addressed counter as part of the read
//   rd_valid       read data valid, one cycle after rd_en
//   rd_data        counter value as it was before the read cycle's update
//   busy           any slot pending or sequencer not idle
module ethernet_stats_collector
  import ethernet_stats_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int CNT_WIDTH = 32,
  parameter int N_TYPES   = N_OF_ETHER_STATS_TYPE,
  localparam int PORT_W   = idxWidth(N_PORTS),
  localparam int TYPE_W   = idxWidth(N_TYPES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_PORTS-1:0]           stats_valid,
  input  logic [N_PORTS*N_TYPES-1:0]   stats_vector,
  output logic [N_PORTS-1:0]           stats_drop,
  input  logic                         rd_en,
  input  logic [PORT_W-1:0]            rd_port,
  input  logic [TYPE_W-1:0]            rd_type,
  input  logic                         rd_clear,
  output logic                         rd_valid,
  output logic [CNT_WIDTH-1:0]         rd_data,
  output logic                         busy
);

  stats_fsm_e r_state;
  stats_fsm_e w_nextState;

  logic [N_PORTS-1:0]   r_pend;
  logic [N_TYPES-1:0]   r_pendVec [N_PORTS];
  logic [N_PORTS-1:0]   r_drop;
  logic [N_TYPES-1:0]   r_workVec;
  logic [PORT_W-1:0]    r_port;
  logic [TYPE_W-1:0]    r_idx;
  logic [CNT_WIDTH-1:0] r_cnt [N_PORTS][N_TYPES];
  logic                 r_rdValid;
  logic [CNT_WIDTH-1:0] r_rdData;

  logic [N_PORTS-1:0]   w_grantOh;
  logic [PORT_W-1:0]    w_grantIdx;
  logic                 w_grantValid;
  logic                 w_advance;
  logic                 w_rdInRange;
  logic [N_TYPES-1:0]   w_inc [N_PORTS];
  logic [N_TYPES-1:0]   w_clr [N_PORTS];

  ethernet_stats_rr_arbiter #(
    .N (N_PORTS)
  ) u_arbiter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (r_pend),
    .i_advance    (w_advance),
    .o_grantOh    (w_grantOh),
    .o_grantIdx   (w_grantIdx),
    .o_grantValid (w_grantValid)
  );

  // A slot is consumed only while the sequencer sits in IDLE
  assign w_advance = (r_state == IDLE) && w_grantValid;

  // Pending slots: a slot freed by this cycle's grant can take a new strobe
  // in the same cycle, so only a truly occupied slot causes a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_drop <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        r_pendVec[p] <= '0;
      end
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (stats_valid[p] && (!r_pend[p] || (w_advance && w_grantOh[p]))) begin
          r_pend[p]    <= 1'b1;
          r_pendVec[p] <= stats_vector[p*N_TYPES +: N_TYPES];
        end else if (w_advance && w_grantOh[p]) begin
          r_pend[p]    <= 1'b0;
        end
        r_drop[p] <= stats_valid[p] && r_pend[p] && !(w_advance && w_grantOh[p]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Zero vectors bounce straight back to IDLE from GRANT
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_grantValid) begin
          w_nextState = GRANT;
        end
      end
      GRANT: begin
        w_nextState = (r_workVec == '0) ? IDLE : UPDATE;
      end
      UPDATE: begin
        if (r_idx == TYPE_W'(N_TYPES-1)) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Sequencer datapath: capture the winner's vector, then walk the type index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_workVec <= '0;
      r_port    <= '0;
      r_idx     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_workVec <= r_pendVec[w_grantIdx];
            r_port    <= w_grantIdx;
          end
        end
        GRANT:   r_idx <= '0;
        UPDATE:  r_idx <= r_idx + TYPE_W'(1);
        default: r_idx <= '0;
      endcase
    end
  end

  assign w_rdInRange = (int'(rd_port) < N_PORTS) && (int'(rd_type) < N_TYPES);

  // Per-counter increment and clear enables
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      w_inc[p] = '0;
      w_clr[p] = '0;
      for (int t = 0; t < N_TYPES; t++) begin
        w_inc[p][t] = (r_state == UPDATE) && (r_port == PORT_W'(p)) &&
                      (r_idx == TYPE_W'(t)) && r_workVec[t];
        w_clr[p][t] = rd_en && rd_clear && w_rdInRange &&
                      (rd_port == PORT_W'(p)) && (rd_type == TYPE_W'(t));
      end
    end
  end

  // Counter array and host read. A clear that collides with an increment
  // leaves 1 so the colliding event is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        for (int t = 0; t < N_TYPES; t++) begin
          r_cnt[p][t] <= '0;
        end
      end
    end else begin
      r_rdValid <= rd_en;
      if (rd_en) begin
        r_rdData <= w_rdInRange ? r_cnt[rd_port][rd_type] : '0;
      end
      for (int p = 0; p < N_PORTS; p++) begin
        for (int t = 0; t < N_TYPES; t++) begin
          if (w_clr[p][t]) begin
            r_cnt[p][t] <= w_inc[p][t] ? CNT_WIDTH'(1) : '0;
          end else if (w_inc[p][t] && (r_cnt[p][t] != '1)) begin
            r_cnt[p][t] <= r_cnt[p][t] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign stats_drop = r_drop;
  assign rd_valid   = r_rdValid;
  assign rd_data    = r_rdData;
  assign busy       = (|r_pend) || (r_state != IDLE);

endmodule

// File: tb/tb_ethernet_stats_collector.sv
// tb_ethernet_stats_collector
// Self-checking bench: directed scenarios plus randomized bursts compared
// against a per-report counter model (each accepted report adds one to every
// set type, saturating at 255).
module tb_ethernet_stats_collector;

  localparam int NP = 4;
  localparam int NT = 7;
  localparam int CW = 8;
  localparam int SAT = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     stats_valid = '0;
  logic [NP*NT-1:0]  stats_vector = '0;
  logic [NP-1:0]     stats_drop;
  logic              rd_en = 1'b0;
  logic [1:0]        rd_port = '0;
  logic [2:0]        rd_type = '0;
  logic              rd_clear = 1'b0;
  logic              rd_valid;
  logic [CW-1:0]     rd_data;
  logic              busy;

  int checkCount = 0;
  int passCount = 0;
  int dropCount = 0;
  int expectedDrops = 0;
  int modelCnt [NP][NT];

  always #5 clk = ~clk;

  ethernet_stats_collector #(
    .N_PORTS   (NP),
    .CNT_WIDTH (CW),
    .N_TYPES   (NT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stats_valid  (stats_valid),
    .stats_vector (stats_vector),
    .stats_drop   (stats_drop),
    .rd_en        (rd_en),
    .rd_port      (rd_port),
    .rd_type      (rd_type),
    .rd_clear     (rd_clear),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .busy         (busy)
  );

  // Drop pulses seen by the bench
  always @(negedge clk) begin
    dropCount += $countones(stats_drop);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void modelAccept(input int p, input logic [NT-1:0] v);
    for (int t = 0; t < NT; t++) begin
      if (v[t] && modelCnt[p][t] < SAT) begin
        modelCnt[p][t]++;
      end
    end
  endfunction

  function automatic void modelReset();
    for (int p = 0; p < NP; p++) begin
      for (int t = 0; t < NT; t++) begin
        modelCnt[p][t] = 0;
      end
    end
  endfunction

  // One-cycle strobe on the masked ports; caller guarantees empty slots
  task automatic applyStimulus(input logic [NP-1:0] mask, input logic [NP*NT-1:0] vecs);
    @(negedge clk);
    stats_valid  = mask;
    stats_vector = vecs;
    @(negedge clk);
    stats_valid  = '0;
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        modelAccept(p, vecs[p*NT +: NT]);
      end
    end
  endtask

  // Counts negedges with busy high; bounded
  task automatic waitIdle(output int busyHigh);
    int n;
    busyHigh = 0;
    n = 0;
    while (busy && n < 2000) begin
      busyHigh++;
      n++;
      @(negedge clk);
    end
    if (busy) begin
      checkOutput("idleTimeout", 32'(busy), 0);
    end
  endtask

  task automatic doRead(input int p, input int t, input bit clr, output logic [CW-1:0] data);
    @(negedge clk);
    rd_en    = 1'b1;
    rd_port  = p[1:0];
    rd_type  = t[2:0];
    rd_clear = clr;
    @(negedge clk);
    rd_en    = 1'b0;
    rd_clear = 1'b0;
    checkOutput($sformatf("rdValid p%0d t%0d", p, t), 32'(rd_valid), 1);
    data = rd_data;
  endtask

  task automatic readCheck(input int p, input int t, input bit clr);
    logic [CW-1:0] d;
    int expVal;
    expVal = 0;
    if (t < NT) begin
      expVal = modelCnt[p][t];
    end
    doRead(p, t, clr, d);
    checkOutput($sformatf("rdData p%0d t%0d clr%0d", p, t, clr), 32'(d), expVal);
    if (clr && t < NT) begin
      modelCnt[p][t] = 0;
    end
  endtask

  function automatic logic [NP*NT-1:0] portVec(input int p, input logic [NT-1:0] v);
    logic [NP*NT-1:0] f;
    f = '0;
    f[p*NT +: NT] = v;
    return f;
  endfunction

  initial begin
    int bh;
    logic [NP*NT-1:0] flat;
    logic [NP-1:0] mask;
    logic [CW-1:0] d;

    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", 32'(busy), 0);
    checkOutput("resetRdValid", 32'(rd_valid), 0);
    checkOutput("resetRdData", 32'(rd_data), 0);
    checkOutput("resetDrop", 32'(stats_drop), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single report: valid + unicast on port 0
    applyStimulus(4'b0001, portVec(0, 7'b1000001));
    waitIdle(bh);
    checkOutput("singleBusyCycles", bh, 9);
    for (int t = 0; t < NT; t++) readCheck(0, t, 1'b0);

    // All ports at once
    flat = '0;
    for (int p = 0; p < NP; p++) flat[p*NT +: NT] = 7'b1000010;
    applyStimulus(4'b1111, flat);
    waitIdle(bh);
    checkOutput("allPortsBusyCycles", bh, 36);
    checkOutput("allPortsDrops", dropCount, expectedDrops);
    for (int p = 0; p < NP; p++) begin
      readCheck(p, 1, 1'b0);
      readCheck(p, 6, 1'b0);
    end

    // Zero vector: slot freed at grant, no UPDATE walk
    applyStimulus(4'b1000, portVec(3, 7'b0000000));
    waitIdle(bh);
    checkOutput("zeroVecBusyCycles", bh, 2);

    // Port 2 strobes twice while port 0 is being serviced
    @(negedge clk);
    stats_valid = 4'b0001; stats_vector = portVec(0, 7'b1000000);
    @(negedge clk);
    stats_valid = 4'b0100; stats_vector = portVec(2, 7'b1000000);
    @(negedge clk);
    stats_valid = 4'b0100; stats_vector = portVec(2, 7'b1000000);
    @(negedge clk);
    stats_valid = '0;
    modelAccept(0, 7'b1000000);
    modelAccept(2, 7'b1000000);
    expectedDrops++;
    waitIdle(bh);
    checkOutput("doubleStrobeDrops", dropCount, expectedDrops);
    readCheck(2, 6, 1'b0);
    readCheck(0, 6, 1'b0);

    // Randomized bursts with interleaved random reads
    for (int b = 0; b < 20; b++) begin
      mask = 4'($urandom_range(1, 15));
      flat = '0;
      for (int p = 0; p < NP; p++) flat[p*NT +: NT] = 7'($urandom);
      applyStimulus(mask, flat);
      waitIdle(bh);
      readCheck($urandom_range(0, NP-1), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end
    checkOutput("randomDrops", dropCount, expectedDrops);
    for (int p = 0; p < NP; p++) begin
      for (int t = 0; t < NT; t++) readCheck(p, t, 1'b0);
    end

    // Saturation on (1,6)
    readCheck(1, 6, 1'b1);
    for (int i = 0; i < 257; i++) begin
      applyStimulus(4'b0010, portVec(1, 7'b1000000));
      waitIdle(bh);
    end
    readCheck(1, 6, 1'b0);
    readCheck(1, 6, 1'b1);
    readCheck(1, 6, 1'b0);

    // Clear-on-read colliding with the increment of the same counter
    readCheck(0, 6, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0001, portVec(0, 7'b1000000));
      waitIdle(bh);
    end
    @(negedge clk);
    stats_valid = 4'b0001; stats_vector = portVec(0, 7'b1000000);
    @(negedge clk);
    stats_valid = '0;
    repeat (8) @(negedge clk);
    rd_en = 1'b1; rd_port = 2'd0; rd_type = 3'd6; rd_clear = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; rd_clear = 1'b0;
    checkOutput("collideRdValid", 32'(rd_valid), 1);
    checkOutput("collideRdData", 32'(rd_data), 5);
    modelCnt[0][6] = 1;
    waitIdle(bh);
    readCheck(0, 6, 1'b0);

    // Reset in the middle of UPDATE, with a read response in flight
    @(negedge clk);
    stats_valid = 4'b0001; stats_vector = portVec(0, 7'b1111111);
    @(negedge clk);
    stats_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rd_en = 1'b1; rd_port = 2'd0; rd_type = 3'd6;
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput("preResetRdData", 32'(rd_data), 1);
    checkOutput("preResetBusy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetBusy", 32'(busy), 0);
    checkOutput("midResetRdValid", 32'(rd_valid), 0);
    checkOutput("midResetRdData", 32'(rd_data), 0);
    checkOutput("midResetDrop", 32'(stats_drop), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    repeat (12) @(negedge clk);
    checkOutput("postResetBusy", 32'(busy), 0);
    checkOutput("postResetDrops", dropCount, expectedDrops);
    for (int p = 0; p < NP; p++) begin
      for (int t = 0; t < NT; t++) readCheck(p, t, 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
